// File: rtl/axil_write_link.sv
// Single-shot AXI4-Lite write master wired to a register-file slave; start to done is 4 clocks.
// Optional macro AXIL_ALIGN_CHECK_EN makes the slave reject misaligned writes with SLVERR.
module axil_write_link #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int ADDRESS    = 13
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            resp,
    output logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-3:0] rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] mon_awaddr,
    output logic                  mon_awvalid,
    output logic                  mon_awready,
    output logic [DATA_WIDTH-1:0] mon_wdata,
    output logic                  mon_wvalid,
    output logic                  mon_wready,
    output logic [1:0]            mon_bresp,
    output logic                  mon_bvalid,
    output logic                  mon_bready
);

    localparam int NREGS = 1 << (ADDR_WIDTH - 2);
    localparam logic [ADDR_WIDTH-1:0] TARGET = ADDR_WIDTH'(ADDRESS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  bready_q, bready_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [1:0]            resp_q, resp_d;

    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic                  accept, write_en, misaligned;

    // Master: AW and W retire independently; B is awaited only once both have.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bready_d  = bready_q;
        done_d    = 1'b0;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wdata_d   = wr_data;
                    awaddr_d  = TARGET;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (awvalid_q && awready_q) awvalid_d = 1'b0;
                if (wvalid_q && wready_q)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bvalid_q && bready_q) begin
                    resp_d   = bresp_q;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            resp_q    <= resp_d;
        end
    end

    // Slave: readies pulse together for one cycle, so AW is never taken without W.
    assign accept   = awvalid_q && wvalid_q && !awready_q && !bvalid_q;
    assign write_en = awvalid_q && awready_q;

`ifdef AXIL_ALIGN_CHECK_EN
    assign misaligned = |awaddr_q[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            awready_q <= accept;
            wready_q  <= accept;
            if (write_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= misaligned ? 2'b10 : 2'b00;
                if (!misaligned) regs[awaddr_q[ADDR_WIDTH-1:2]] <= wdata_q;
            end else if (bvalid_q && bready_q) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign rd_data     = regs[rd_idx];
    assign busy        = busy_q;
    assign done        = done_q;
    assign resp        = resp_q;
    assign data        = wdata_q;
    assign mon_awaddr  = awaddr_q;
    assign mon_awvalid = awvalid_q;
    assign mon_awready = awready_q;
    assign mon_wdata   = wdata_q;
    assign mon_wvalid  = wvalid_q;
    assign mon_wready  = wready_q;
    assign mon_bresp   = bresp_q;
    assign mon_bvalid  = bvalid_q;
    assign mon_bready  = bready_q;

endmodule

// File: tb/tb_axil_write_link.sv
// Directed plus randomized bench for axil_write_link against a word-array model of the register file.
module tb_axil_write_link;

    localparam int DW      = 32;
    localparam int AW      = 4;
    localparam int ADDRESS = 13;
    localparam int NREGS   = 1 << (AW - 2);
    localparam int EXP_IDX = (ADDRESS % (1 << AW)) / 4;
`ifdef AXIL_ALIGN_CHECK_EN
    localparam bit EXP_ERR = (ADDRESS % 4) != 0;
`else
    localparam bit EXP_ERR = 1'b0;
`endif
    localparam logic [1:0]    EXP_RESP   = EXP_ERR ? 2'b10 : 2'b00;
    localparam logic [AW-1:0] EXP_AWADDR = AW'(ADDRESS % (1 << AW));

    logic          aclk, areset, start;
    logic [DW-1:0] wr_data;
    logic          busy, done;
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic [AW-3:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mon_awaddr;
    logic          mon_awvalid, mon_awready, mon_wvalid, mon_wready, mon_bvalid, mon_bready;
    logic [DW-1:0] mon_wdata;
    logic [1:0]    mon_bresp;

    axil_write_link #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDRESS(ADDRESS)) dut (
        .aclk(aclk), .areset(areset), .start(start), .wr_data(wr_data),
        .busy(busy), .done(done), .resp(resp), .data(data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .mon_awaddr(mon_awaddr), .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
        .mon_wdata(mon_wdata), .mon_wvalid(mon_wvalid), .mon_wready(mon_wready),
        .mon_bresp(mon_bresp), .mon_bvalid(mon_bvalid), .mon_bready(mon_bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            dones = 0;
    logic [DW-1:0] mem [NREGS];
    logic [1:0]    last_resp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (done === 1'b1) dones++;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            rd_idx = (AW-2)'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), rd_data, mem[i]);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_awvalid"}, mon_awvalid, 1'b0);
        check({tag, "_wvalid"},  mon_wvalid,  1'b0);
        check({tag, "_awready"}, mon_awready, 1'b0);
        check({tag, "_wready"},  mon_wready,  1'b0);
        check({tag, "_bvalid"},  mon_bvalid,  1'b0);
        check({tag, "_bready"},  mon_bready,  1'b0);
        check({tag, "_done"},    done,        1'b0);
        check({tag, "_busy"},    busy,        1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_done", done, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
    endtask

    // One write from the start cycle through the done sample; 'extra' keeps start
    // asserted with another word while the link is busy, which must be dropped.
    task automatic do_write(input logic [DW-1:0] d, input bit extra);
        int d0;
        d0 = dones;
        start = 1'b1;
        wr_data = d;
        tick();
        start = 1'b0;
        check("e0_busy", busy, 1'b1);
        check("e0_awvalid", mon_awvalid, 1'b1);
        check("e0_wvalid", mon_wvalid, 1'b1);
        check("e0_awaddr", mon_awaddr, EXP_AWADDR);
        check("e0_wdata", mon_wdata, d);
        check("e0_data", data, d);
        check("e0_awready", mon_awready, 1'b0);
        check("e0_done", done, 1'b0);
        check("e0_resp_hold", resp, last_resp);
        if (extra) begin
            start = 1'b1;
            wr_data = 32'h12345678;
        end
        tick();
        check("e1_awready", mon_awready, 1'b1);
        check("e1_wready", mon_wready, 1'b1);
        check("e1_awvalid", mon_awvalid, 1'b1);
        check("e1_wvalid", mon_wvalid, 1'b1);
        check("e1_bvalid", mon_bvalid, 1'b0);
        check("e1_done", done, 1'b0);
        tick();
        if (!EXP_ERR) mem[EXP_IDX] = d;
        check("e2_awready", mon_awready, 1'b0);
        check("e2_wready", mon_wready, 1'b0);
        check("e2_awvalid", mon_awvalid, 1'b0);
        check("e2_wvalid", mon_wvalid, 1'b0);
        check("e2_bvalid", mon_bvalid, 1'b1);
        check("e2_bready", mon_bready, 1'b1);
        check("e2_bresp", mon_bresp, EXP_RESP);
        check("e2_done", done, 1'b0);
        check("e2_busy", busy, 1'b1);
        tick();
        start = 1'b0;
        last_resp = EXP_RESP;
        check("e3_done", done, 1'b1);
        check("e3_busy", busy, 1'b0);
        check("e3_resp", resp, EXP_RESP);
        check("e3_bvalid", mon_bvalid, 1'b0);
        check("e3_bready", mon_bready, 1'b0);
        check("e3_data", data, d);
        check("done_count", dones - d0, 1);
        check_regs("wr");
    endtask

    initial begin
        logic [DW-1:0] rnd;
        areset = 1'b1;
        start = 1'b0;
        wr_data = '0;
        rd_idx = '0;
        last_resp = 2'b00;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        repeat (3) tick();
        check_quiet("rst");
        check("rst_resp", resp, 2'b00);
        check("rst_data", data, 0);
        check("rst_awaddr", mon_awaddr, 0);
        check("rst_wdata", mon_wdata, 0);
        check_regs("rst");
        areset = 1'b0;
        idle(2);

        do_write(32'hDEADBEEF, 1'b0);
        idle(2);
        do_write(32'hCAFEF00D, 1'b1);
        do_write(32'h0BADF00D, 1'b0);
        idle(1);

        // Reset in the cycle after awvalid rises aborts with no response.
        start = 1'b1;
        wr_data = 32'h55AA55AA;
        tick();
        start = 1'b0;
        check("abort_awvalid_up", mon_awvalid, 1'b1);
        areset = 1'b1;
        tick();
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        last_resp = 2'b00;
        check_quiet("abort");
        check("abort_data", data, 0);
        check_regs("abort");
        areset = 1'b0;
        idle(4);

        for (int k = 0; k < 20; k++) begin
            rnd = $urandom;
            do_write(rnd, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axil_write_link.md
Name: axil_write_link

Overview:
- Self-contained AXI4-Lite write path: a single-shot write master wired internally to a register-file slave on one clock.
- A start pulse makes the master issue one AXI4-Lite write of a captured data word to a fixed target address.
- The slave stores the word and returns a write response.
- The internal AW/W/B channel signals are exported read-only for bus monitoring; the register file is exported through a combinational read port.

Parameters:
- DATA_WIDTH, 32: AXI data width, wdata and register width.
- ADDR_WIDTH, 4: AXI byte-address width. The register file holds 2^(ADDR_WIDTH-2) words (4 by default).
- ADDRESS, 13: byte address driven on awaddr for every write (ADDR_WIDTH bits, upper bits truncated).

Ports:
- aclk  in  1  single clock, rising edge.
- areset  in  1  reset.
- start  in  1  one-cycle request to issue a write; ignored while busy=1.
- wr_data  in  DATA_WIDTH  word to write, sampled on the start cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the B handshake completes.
- resp  out  2  bresp captured at the B handshake; holds until the next B handshake.
- data  out  DATA_WIDTH  last word sampled by the master (the value driven on wdata).
- rd_idx  in  ADDR_WIDTH-2  register file read index.
- rd_data  out  DATA_WIDTH  combinational register file contents at rd_idx.
- mon_awaddr, mon_awvalid, mon_awready, mon_wdata, mon_wvalid, mon_wready, mon_bresp, mon_bvalid, mon_bready  out  per AXI4-Lite  copies of the internal channel signals; awprot is internally tied to 3'b000.

Behaviour:
- Reset: synchronous, active-high, applied on the aclk rising edge. Reset mid-transaction aborts the transaction with no response and no done pulse.
- Reset values: all valid/ready/done/busy = 0, resp = 2'b00, data = 0, awaddr = 0, wdata = 0, all registers = 0.
- All outputs except rd_data are registered.
- Master FSM states:
  - IDLE: on start, latch wr_data into data/wdata, drive awaddr=ADDRESS, set awvalid=wvalid=1, go to ADDR.
  - ADDR: awvalid clears independently on its awvalid&awready edge; wvalid likewise on wvalid&wready. awvalid/awaddr and wvalid/wdata stay stable until their own handshake. When both handshakes are done, set bready=1 and go to RESP.
  - RESP: on bvalid&bready, capture bresp into resp, clear bready, pulse done for 1 cycle, go to IDLE.
- start during ADDR or RESP is dropped; there is no queueing.
- Slave ready generation:
  - awready and wready assert together for exactly one cycle when awvalid & wvalid & !awready & !bvalid.
  - The slave never accepts AW without W.
- Slave write: in that same accepting cycle, register[awaddr[ADDR_WIDTH-1:2]] <= wdata. awaddr[1:0] is ignored (ADDRESS=13 maps to index 3). There are no strobes, so the full word is written.
- Slave response: bvalid=1, bresp=2'b00 on the edge after acceptance. bvalid holds until bready, then clears on that edge.
- Nominal timing, start sampled at edge 0:
  - awvalid/wvalid high after edge 0.
  - awready/wready high after edge 1.
  - Register written and bvalid high after edge 2.
  - bready is already high, so done pulses after edge 3.
  - busy falls with done.
- Back-to-back: start may be accepted in the cycle after done.

Optional Feature:
- Macro AXIL_ALIGN_CHECK_EN.
- When defined: the slave checks awaddr[1:0] at acceptance.
  - Nonzero: the register is not written and bresp=2'b10 (SLVERR).
  - Zero: normal write with OKAY.
- When undefined: low address bits are ignored and every write returns 2'b00.
- Handshake timing is identical in both builds.

Test Plan:
- Reset: hold areset 3 cycles -> every output 0, rd_data=0 for idx 0..3, busy=0.
- Default build, ADDRESS=13, start with wr_data=0xDEADBEEF -> mon_awaddr=4'hD, awready/wready one cycle, done 4 edges after start, resp=2'b00, rd_data[3]=0xDEADBEEF, data=0xDEADBEEF.
- Pulse start again during busy with wr_data=0x12345678 -> ignored; register 3 stays 0xDEADBEEF and exactly one done pulse occurs.
- Assert areset in the cycle after awvalid rises -> next cycle all valids/readies 0, no done, registers 0.
- AXIL_ALIGN_CHECK_EN, ADDRESS=13, wr_data=0xA5A5A5A5 -> resp=2'b10, register 3 unchanged (0).
- AXIL_ALIGN_CHECK_EN, ADDRESS=12, wr_data=0xA5A5A5A5 -> resp=2'b00, register 3 = 0xA5A5A5A5.
